// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, in-flight slot record, forward-select codes.
// Slot rd is sized for the largest supported register file; narrower addresses are zero-extended.
package pipe_pkg;

  localparam int REG_AW_MAX = 8;
  typedef logic [REG_AW_MAX-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    BR_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      is_load;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Youngest producer wins: the one now in EX will sit in MEM when the consumer reaches EX.
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_MEM;
    if (hit_mem) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination tracker (slot0=EX .. slot NSLOT-1) with per-slot source-match vectors.
// One-cycle shift per clock, no backpressure: an unissued cycle shifts in an invalid slot.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NSLOT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  slot_t            push_slot,
  input  reg_addr_t        rs1_addr,
  input  logic             rs1_en,
  input  reg_addr_t        rs2_addr,
  input  logic             rs2_en,
  output logic [NSLOT-1:0] rs1_match,
  output logic [NSLOT-1:0] rs2_match,
  output logic             load_in_ex
);

  slot_t [NSLOT-1:0] slot_q;
  slot_t [NSLOT-1:0] slot_d;

  always_comb begin
    slot_d = {slot_q[NSLOT-2:0], push_slot};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // rs_en gates first so unused address fields never contribute.
  always_comb begin
    rs1_match = '0;
    rs2_match = '0;
    for (int i = 0; i < NSLOT; i++) begin
      rs1_match[i] = rs1_en & slot_q[i].valid & (slot_q[i].rd == rs1_addr);
      rs2_match[i] = rs2_en & slot_q[i].valid & (slot_q[i].rd == rs2_addr);
    end
    load_in_ex = slot_q[0].valid & slot_q[0].is_load;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush control for an in-order pipeline; controls are combinational, fwd_sel registered at issue.
// ID is held on data hazards and unresolved branches; define PIPE_HAZARD_FORWARD_EN for load-use-only stalls.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int NSLOT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  input  logic                    rs1_en,
  input  logic                    rs2_en,
  input  logic                    reg_write_en,
  input  logic                    mem_read_en,
  input  logic                    branch_en,
  input  logic                    ex_br_resolved,
  input  logic                    ex_br_taken,
  output logic                    issue,
  output logic                    if_stall,
  output logic                    id_ex_bubble,
  output logic                    if_id_flush,
  output logic [1:0]              fwd_sel_a,
  output logic [1:0]              fwd_sel_b
);

  hz_state_e        state_q, state_d;
  logic [NSLOT-1:0] rs1_match, rs2_match;
  logic             load_in_ex;
  logic             hazard, br_wait, br_take, data_stall;
  slot_t            push_slot;

  pipe_scoreboard #(.NSLOT(NSLOT)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_slot  (push_slot),
    .rs1_addr   (reg_addr_t'(rs1_addr)),
    .rs1_en     (rs1_en),
    .rs2_addr   (reg_addr_t'(rs2_addr)),
    .rs2_en     (rs2_en),
    .rs1_match  (rs1_match),
    .rs2_match  (rs2_match),
    .load_in_ex (load_in_ex)
  );

  always_comb begin
`ifdef PIPE_HAZARD_FORWARD_EN
    hazard = (rs1_match[0] | rs2_match[0]) & load_in_ex;
`else
    hazard = |{rs1_match[1:0], rs2_match[1:0]};
`endif
  end

  // A taken branch resolving in EX squashes ID regardless of any data hazard.
  always_comb begin
    br_wait      = (state_q == BR_WAIT) & ~ex_br_resolved;
    br_take      = (state_q == BR_WAIT) & ex_br_resolved & ex_br_taken;
    data_stall   = id_valid & hazard & ~br_wait & ~br_take;
    issue        = id_valid & ~hazard & ~br_wait & ~br_take;
    if_stall     = br_wait | data_stall;
    id_ex_bubble = br_wait | data_stall | br_take;
    if_id_flush  = br_take;

    state_d = RUN;
    if (br_wait)                 state_d = BR_WAIT;
    else if (data_stall)         state_d = STALL;
    else if (issue && branch_en) state_d = BR_WAIT;

    push_slot         = '0;
    push_slot.valid   = issue & reg_write_en & (rd_addr != '0);
    push_slot.rd      = reg_addr_t'(rd_addr);
    push_slot.is_load = mem_read_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_HAZARD_FORWARD_EN
  logic [1:0] fwd_sel_a_q, fwd_sel_a_d;
  logic [1:0] fwd_sel_b_q, fwd_sel_b_d;

  always_comb begin
    fwd_sel_a_d = issue ? fwd_pick(rs1_match[0], rs1_match[1]) : FWD_RF;
    fwd_sel_b_d = issue ? fwd_pick(rs2_match[0], rs2_match[1]) : FWD_RF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel_a_q <= FWD_RF;
      fwd_sel_b_q <= FWD_RF;
    end else begin
      fwd_sel_a_q <= fwd_sel_a_d;
      fwd_sel_b_q <= fwd_sel_b_d;
    end
  end

  assign fwd_sel_a = fwd_sel_a_q;
  assign fwd_sel_b = fwd_sel_b_q;
`else
  assign fwd_sel_a = FWD_RF;
  assign fwd_sel_b = FWD_RF;
`endif

  // The WB slot only tracks retirement; its match bits feed no decision.
  logic unused_ok;
  assign unused_ok = &{1'b0, rs1_match, rs2_match, load_in_ex};

endmodule
